// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM stage: control-bit positions
// inside the EX/MEM control fields and the access FSM encoding.
package mem_stage_ctrl_pkg;

   // M field bit positions
   localparam int unsigned MEMREAD  = 1;
   localparam int unsigned MEMWRITE = 0;
   // WB field bit positions
   localparam int unsigned REGWRITE = 1;
   localparam int unsigned MEMTOREG = 0;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
// Handshake: mem_req_o stays high with stable mem_we_o/mem_addr_o/mem_wdata_o until a cycle with
// mem_ack_i high; read data in mem_rdata_i is valid in that same cycle, and the access retires on that edge.
interface mem_stage_ctrl_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register; bubble_i loads an all-zero (no-op) entry.
module mem_wb_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bubble_i,
   input  logic [1:0]  wb_d,
   input  logic [31:0] alu_d,
   input  logic [4:0]  rd_d,
   input  logic [31:0] rdata_d,
   output logic [1:0]  wb_q,
   output logic [31:0] alu_q,
   output logic [4:0]  rd_q,
   output logic [31:0] rdata_q
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wb_q    <= '0;
         alu_q   <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else if (bubble_i) begin
         wb_q    <= '0;
         alu_q   <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
      end else begin
         wb_q    <= wb_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: decodes M controls, runs a multi-cycle memory handshake with
// timeout, stalls the front of the pipeline and feeds the MEM/WB register.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             WB_i,
   input  logic [1:0]             M_i,
   input  logic [31:0]            addr_i,
   input  logic [31:0]            data_i,
   input  logic [4:0]             rd_i,
   mem_stage_ctrl_if.master       mem,
   output logic                   stall_o,
   output logic                   err_o,
   output logic [1:0]             WB_o,
   output logic [31:0]            rdata_o,
   output logic [31:0]            alu_o,
   output logic [4:0]             rd_o,
   output state_t                 dbg_state_o
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          hold_we_q;
   logic [31:0]   hold_addr_q, hold_data_q;
   logic [1:0]    hold_wb_q;
   logic [4:0]    hold_rd_q;
   logic          err_q;

   logic          acc, timeout_hit;
   logic          stall_c, bubble, hold_load, cnt_inc, set_err;
   logic [1:0]    wb_d;
   logic [31:0]   alu_d, rdata_d;
   logic [4:0]    rd_d;

   assign acc         = M_i[MEMREAD] | M_i[MEMWRITE];
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      stall_c       = 1'b0;
      bubble        = 1'b1;
      hold_load     = 1'b0;
      cnt_inc       = 1'b0;
      set_err       = 1'b0;
      wb_d          = '0;
      alu_d         = '0;
      rd_d          = '0;
      rdata_d       = '0;
      mem.mem_req_o = 1'b0;
      mem.mem_we_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               stall_c   = 1'b1;
               hold_load = 1'b1;
               state_d   = REQ;
            end else begin
               bubble = 1'b0;
               wb_d   = WB_i;
               alu_d  = addr_i;
               rd_d   = rd_i;
            end
         end
         REQ: begin
            mem.mem_req_o = 1'b1;
            mem.mem_we_o  = hold_we_q;
            // An ack in the final allowed cycle still counts as a normal completion.
            if (mem.mem_ack_i || timeout_hit) begin
               bubble  = 1'b0;
               wb_d    = hold_wb_q;
               alu_d   = hold_addr_q;
               rd_d    = hold_rd_q;
               set_err = !mem.mem_ack_i;
               if (!mem.mem_ack_i) rdata_d = ERR_DATA;
               else if (!hold_we_q) rdata_d = mem.mem_rdata_i;
               state_d = IDLE;
            end else begin
               stall_c = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_we_q   <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         hold_wb_q   <= '0;
         hold_rd_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (hold_load) begin
            hold_we_q   <= M_i[MEMWRITE];
            hold_addr_q <= addr_i;
            hold_data_q <= data_i;
            hold_wb_q   <= WB_i;
            hold_rd_q   <= rd_i;
            cnt_q       <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (set_err) err_q <= 1'b1;
      end
   end

   // Reset must silence the stall even while EX/MEM still presents an access.
   assign stall_o         = rst_i & stall_c;
   assign err_o           = err_q;
   assign mem.mem_addr_o  = hold_addr_q;
   assign mem.mem_wdata_o = hold_data_q;
   assign dbg_state_o     = state_q;

   mem_wb_reg u_mem_wb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bubble_i (bubble),
      .wb_d     (wb_d),
      .alu_d    (alu_d),
      .rd_d     (rd_d),
      .rdata_d  (rdata_d),
      .wb_q     (WB_o),
      .alu_q    (alu_o),
      .rd_q     (rd_o),
      .rdata_q  (rdata_o)
   );

endmodule
